alu_multicycle: RTL and testbench

Parametrised successor to the single-cycle datapath ALU. It adds registered outputs, signed overflow detection, NOR and signed set-less-than, plus iterative unsigned multiply and divide that write a HI/LO register pair. It sits in the EX stage of the multi-cycle CPU. The controller starts an operation with `start_i` and stalls on `busy_o` until `done_o`.

---
 rtl/alu_multicycle_if.sv | 27 ++
 rtl/alu_multicycle.sv | 183 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the EX-stage controller and alu_multicycle.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             zero_o;
  logic             overflow_o;
  logic             div0_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  result_o, hi_o, lo_o, zero_o, overflow_o, div0_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output result_o, hi_o, lo_o, zero_o, overflow_o, div0_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// EX-stage ALU: registered single-cycle ops plus iterative shift-add MULTU
// and restoring DIVU that write the HI/LO pair after WIDTH cycles.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  alu_multicycle_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_NOR   = 4'b1100,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001
  } op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic             last;

  always_comb begin
    sum  = bus.src1_i + bus.src2_i;
    diff = bus.src1_i - bus.src2_i;
    // Multiply: wh holds the running upper half, wl the unconsumed multiplier bits.
    mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opa_q} : '0);
    // Divide: wh is the partial remainder, wl shifts dividend out and quotient in.
    div_shift = {wh_q, wl_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opa_q};
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opa_q}) : div_shift[WIDTH-1:0];
    last      = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    div0_d   = div0_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          case (bus.ctrl_i)
            OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = '0;
              opa_d   = bus.src1_i;
              wh_d    = '0;
              wl_d    = bus.src2_i;
            end
            OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = '0;
              opa_d   = bus.src2_i;
              wh_d    = '0;
              wl_d    = bus.src1_i;
            end
            OP_AND: begin result_d = bus.src1_i & bus.src2_i;    ovf_d = 1'b0; done_d = 1'b1; end
            OP_OR:  begin result_d = bus.src1_i | bus.src2_i;    ovf_d = 1'b0; done_d = 1'b1; end
            OP_NOR: begin result_d = ~(bus.src1_i | bus.src2_i); ovf_d = 1'b0; done_d = 1'b1; end
            OP_ADD: begin
              result_d = sum;
              ovf_d    = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
              done_d   = 1'b1;
            end
            OP_SUB: begin
              result_d = diff;
              ovf_d    = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                         (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
              done_d   = 1'b1;
            end
            OP_SLT: begin
              result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
              ovf_d    = 1'b0;
              done_d   = 1'b1;
            end
            default: begin result_d = '0; ovf_d = 1'b0; done_d = 1'b1; end
          endcase
        end
      end

      S_MUL: begin
        wh_d  = mul_sum[WIDTH:1];
        wl_d  = {mul_sum[0], wl_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          hi_d     = mul_sum[WIDTH:1];
          lo_d     = {mul_sum[0], wl_q[WIDTH-1:1]};
          result_d = {mul_sum[0], wl_q[WIDTH-1:1]};
          ovf_d    = 1'b0;
          done_d   = 1'b1;
        end
      end

      S_DIV: begin
        wh_d  = div_rem;
        wl_d  = {wl_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        // A zero divisor always compares >=, so LO fills with ones and HI ends as A.
        if (last) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          hi_d     = div_rem;
          lo_d     = {wl_q[WIDTH-2:0], div_ge};
          result_d = {wl_q[WIDTH-2:0], div_ge};
          ovf_d    = 1'b0;
          div0_d   = (opa_q == '0);
          done_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      wh_q     <= '0;
      wl_q     <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.zero_o     = (result_q == '0);
  assign bus.overflow_o = ovf_q;
  assign bus.div0_o     = div0_q;
  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed plus random checks of alu_multicycle at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
module tb_alu_multicycle;
  logic clk;
  logic rst_n;

  alu_multicycle_if #(.WIDTH(32)) i32 ();
  alu_multicycle_if #(.WIDTH(8))  i8  ();

  alu_multicycle #(.WIDTH(32)) u32 (.clk_i(clk), .rst_n_i(rst_n), .bus(i32.slave));
  alu_multicycle #(.WIDTH(8))  u8  (.clk_i(clk), .rst_n_i(rst_n), .bus(i8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] o_res, o_hi, o_lo;
  logic        o_zero, o_ovf, o_div0, o_busy, o_done;

  logic [63:0] m_res = '0, m_hi = '0, m_lo = '0;
  logic        m_ovf = 1'b0, m_div0 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [3:0] c,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      i8.start_i = s; i8.ctrl_i = c; i8.src1_i = a[7:0]; i8.src2_i = b[7:0];
    end else begin
      i32.start_i = s; i32.ctrl_i = c; i32.src1_i = a[31:0]; i32.src2_i = b[31:0];
    end
  endtask

  task automatic snap(input bit w8);
    if (w8) begin
      o_res = 64'(i8.result_o); o_hi = 64'(i8.hi_o); o_lo = 64'(i8.lo_o);
      o_zero = i8.zero_o; o_ovf = i8.overflow_o; o_div0 = i8.div0_o;
      o_busy = i8.busy_o; o_done = i8.done_o;
    end else begin
      o_res = 64'(i32.result_o); o_hi = 64'(i32.hi_o); o_lo = 64'(i32.lo_o);
      o_zero = i32.zero_o; o_ovf = i32.overflow_o; o_div0 = i32.div0_o;
      o_busy = i32.busy_o; o_done = i32.done_o;
    end
  endtask

  task automatic model_reset();
    m_res = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_div0 = 1'b0;
  endtask

  // Architectural effect of one completed operation on a w-bit ALU.
  task automatic model(input int unsigned w, input logic [3:0] c,
                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, p;
    longint lim, sa, sb, s;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = (a >= 64'(lim)) ? longint'(a) - 2 * lim : longint'(a);
    sb   = (b >= 64'(lim)) ? longint'(b) - 2 * lim : longint'(b);
    case (c)
      4'b0000: begin m_res = a & b;            m_ovf = 1'b0; end
      4'b0001: begin m_res = a | b;            m_ovf = 1'b0; end
      4'b1100: begin m_res = ~(a | b) & mask;  m_ovf = 1'b0; end
      4'b0010: begin s = sa + sb; m_res = (a + b) & mask; m_ovf = (s >= lim) || (s < -lim); end
      4'b0110: begin s = sa - sb; m_res = (a - b) & mask; m_ovf = (s >= lim) || (s < -lim); end
      4'b0111: begin m_res = (sa < sb) ? 64'd1 : 64'd0; m_ovf = 1'b0; end
      4'b1000: begin
        p = a * b;
        m_hi = p >> w; m_lo = p & mask; m_res = m_lo; m_ovf = 1'b0;
      end
      4'b1001: begin
        if (b == 0) begin m_lo = mask; m_hi = a; m_div0 = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; m_div0 = 1'b0; end
        m_res = m_lo; m_ovf = 1'b0;
      end
      default: begin m_res = '0; m_ovf = 1'b0; end
    endcase
  endtask

  // Issues one op and returns just after its completion edge (inside the done cycle).
  task automatic run_op(input bit w8, input logic [3:0] c, input logic [63:0] a,
                        input logic [63:0] b, input string tag, input bit disturb);
    int unsigned w;
    int          lat, nbusy;
    bit          multi, held;
    w     = w8 ? 8 : 32;
    multi = (c == 4'b1000) || (c == 4'b1001);
    lat   = 0;
    nbusy = 0;
    held  = 1'b1;
    drive(w8, 1'b1, c, a, b);
    @(posedge clk); #1;
    drive(w8, 1'b0, c, a, b);
    snap(w8);
    if (multi) begin
      while (!o_done && lat < 3 * int'(w)) begin
        if (o_busy) nbusy++;
        if (o_hi !== m_hi || o_lo !== m_lo) held = 1'b0;
        if (disturb && lat == 4) drive(w8, 1'b1, 4'b0010, a ^ 64'h5A, b + 64'd3);
        if (disturb && lat == 5) drive(w8, 1'b0, 4'b0000, a ^ 64'h5A, b + 64'd3);
        @(posedge clk); #1;
        lat++;
        snap(w8);
      end
      chk({tag, " latency"}, 64'(lat), 64'(w));
      chk({tag, " busy_cycles"}, 64'(nbusy), 64'(w));
      chk({tag, " hilo_hold"}, 64'(held), 64'd1);
    end
    model(w, c, a, b);
    chk({tag, " done"}, 64'(o_done), 64'd1);
    chk({tag, " busy"}, 64'(o_busy), 64'd0);
    chk({tag, " result"}, o_res, m_res);
    chk({tag, " zero"}, 64'(o_zero), 64'(m_res == 0));
    chk({tag, " ovf"}, 64'(o_ovf), 64'(m_ovf));
    chk({tag, " hi"}, o_hi, m_hi);
    chk({tag, " lo"}, o_lo, m_lo);
    chk({tag, " div0"}, 64'(o_div0), 64'(m_div0));
  endtask

  task automatic check_reset_outputs(input bit w8, input string tag);
    snap(w8);
    chk({tag, " result"}, o_res, 64'd0);
    chk({tag, " hi"}, o_hi, 64'd0);
    chk({tag, " lo"}, o_lo, 64'd0);
    chk({tag, " zero"}, 64'(o_zero), 64'd1);
    chk({tag, " flags"}, {60'd0, o_ovf, o_div0, o_busy, o_done}, 64'd0);
  endtask

  logic [3:0] codes [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                             4'b1100, 4'b1000, 4'b1001, 4'b0011, 4'b1111};

  initial begin
    bit          saw_done;
    logic [63:0] ra, rb;
    logic [3:0]  rc;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 4'b0000, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 check_reset_outputs(1'b0, "reset32");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 4'b0010, 64'h7FFF_FFFF, 64'h1, "add_ovf", 1'b0);
    chk("add_ovf const", o_res, 64'h8000_0000);
    @(posedge clk); #1 snap(1'b0);
    chk("add_ovf done_pulse_end", 64'(o_done), 64'd0);
    chk("add_ovf hold", o_res, 64'h8000_0000);

    run_op(1'b0, 4'b0111, 64'hFFFF_FFFF, 64'h1, "slt", 1'b0);
    chk("slt const", o_res, 64'd1);
    run_op(1'b0, 4'b0110, 64'd5, 64'd5, "sub_zero", 1'b0);
    chk("sub_zero zflag", 64'(o_zero), 64'd1);
    run_op(1'b0, 4'b1100, 64'd0, 64'd0, "nor", 1'b0);
    chk("nor const", o_res, 64'hFFFF_FFFF);
    run_op(1'b0, 4'b0011, 64'h1234, 64'h5678, "undef", 1'b0);
    run_op(1'b0, 4'b0110, 64'h8000_0000, 64'h1, "sub_ovf", 1'b0);

    run_op(1'b0, 4'b1000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "multu_max", 1'b0);
    chk("multu_max hi const", o_hi, 64'hFFFF_FFFE);
    chk("multu_max lo const", o_lo, 64'h1);
    run_op(1'b0, 4'b1001, 64'd100, 64'd7, "divu", 1'b1);
    chk("divu lo const", o_lo, 64'd14);
    chk("divu hi const", o_hi, 64'd2);
    run_op(1'b0, 4'b1001, 64'd5, 64'd0, "divu0", 1'b1);
    chk("divu0 lo const", o_lo, 64'hFFFF_FFFF);
    chk("divu0 hi const", o_hi, 64'd5);
    chk("divu0 flag const", 64'(o_div0), 64'd1);
    run_op(1'b0, 4'b0000, 64'hF0F0_1234, 64'hFF00_FF00, "and_keeps_hilo", 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = 64'($urandom);
      rb = 64'($urandom);
      rc = codes[$urandom_range(0, 9)];
      run_op(1'b0, rc, ra, rb, "rand32", 1'b0);
    end

    // Abort a multiply at iteration 10.
    drive(1'b0, 1'b1, 4'b1000, 64'h1234_5678, 64'h9ABC_DEF0);
    @(posedge clk); #1 drive(1'b0, 1'b0, 4'b1000, 64'h1234_5678, 64'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(1'b0, "abort");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1 snap(1'b0);
      if (o_done || o_busy) saw_done = 1'b1;
    end
    chk("abort no_done", 64'(saw_done), 64'd0);
    run_op(1'b0, 4'b0010, 64'd2, 64'd3, "add_after_abort", 1'b0);
    chk("add_after_abort const", o_res, 64'd5);

    // WIDTH=8 random back-to-back stream.
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs(1'b1, "reset8");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 150; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      rc = codes[$urandom_range(0, 9)];
      run_op(1'b1, rc, ra, rb, "rand8", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
